// File: rtl/quad_gen_if.sv
// Command channel for quad_gen: one move request (direction, step count, step
// period) carried over a valid/ready handshake.
interface quad_gen_if #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 16
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_dir;
   logic [WIDTH-1:0]     cmd_steps;
   logic [DIV_WIDTH-1:0] cmd_period;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, cmd_period,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
      output cmd_ready
   );
endinterface

// File: rtl/quad_gen.sv
// Quadrature generator: emits a Gray-code A/B sequence for a commanded number of
// steps at a programmable rate and tracks the resulting signed position.
module quad_gen #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   quad_gen_if.slave        cmd,
   input  logic             abort,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] position
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   state_t               state, state_next;
   logic                 dir;
   logic [WIDTH-1:0]     remaining;
   logic [DIV_WIDTH-1:0] per;
   logic [DIV_WIDTH-1:0] timer;
   logic                 accept;
   logic                 due;
   logic                 step;

   assign accept = (state == IDLE) && cmd.cmd_valid;
   assign due    = (timer == DIV_WIDTH'(1));
   assign step   = (state == RUN) && due;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (cmd.cmd_valid) begin
               state_next = (cmd.cmd_steps == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            // A due transition is still emitted when abort arrives on the same cycle.
            if (due) begin
               if (remaining == WIDTH'(1) || abort) begin
                  state_next = FINISH;
               end
            end else if (abort) begin
               state_next = FINISH;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd.cmd_ready = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE:    cmd.cmd_ready = 1'b1;
         RUN:     busy          = 1'b1;
         FINISH:  done          = 1'b1;
         default: cmd.cmd_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir       <= 1'b0;
         remaining <= '0;
         per       <= DIV_WIDTH'(1);
         timer     <= DIV_WIDTH'(1);
      end else if (accept) begin
         dir       <= cmd.cmd_dir;
         remaining <= cmd.cmd_steps;
         per       <= (cmd.cmd_period == '0) ? DIV_WIDTH'(1) : cmd.cmd_period;
         timer     <= (cmd.cmd_period == '0) ? DIV_WIDTH'(1) : cmd.cmd_period;
      end else if (state == RUN) begin
         if (due) begin
            remaining <= remaining - WIDTH'(1);
            timer     <= per;
         end else begin
            timer     <= timer - DIV_WIDTH'(1);
         end
      end
   end

   // Forward toggles A when a==b else B; reverse is the mirror image.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a        <= 1'b0;
         b        <= 1'b0;
         position <= '0;
      end else if (step) begin
         if ((a == b) == dir) begin
            a <= ~a;
         end else begin
            b <= ~b;
         end
         position <= dir ? position + WIDTH'(1) : position - WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_quad_gen.sv
// Directed bench for quad_gen: phase sequence, position wrap, zero-step and
// zero-period commands, abort handling and mid-command reset.
module tb_quad_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       abort;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic [7:0] position;
   int         tests = 0;
   int         fails = 0;

   quad_gen_if #(.WIDTH(8), .DIV_WIDTH(16)) cmd_if ();

   quad_gen #(.WIDTH(8), .DIV_WIDTH(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cmd      (cmd_if.slave),
      .abort    (abort),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .position (position)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic d, input logic [7:0] s, input logic [15:0] p);
      cmd_if.cmd_dir    = d;
      cmd_if.cmd_steps  = s;
      cmd_if.cmd_period = p;
      cmd_if.cmd_valid  = 1'b1;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid  = 1'b0;
   endtask

   initial begin
      logic [1:0] seq2_ab  [6] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
      int         seq2_pos [6] = '{3, 2, 1, 0, 255, 254};
      logic [1:0] seq5_ab  [7] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

      reset_n           = 1'b0;
      abort             = 1'b0;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_dir    = 1'b0;
      cmd_if.cmd_steps  = '0;
      cmd_if.cmd_period = '0;

      #2;
      chk("rst_ab", {a, b}, 0);
      chk("rst_pos", position, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cmd_if.cmd_ready, 1);
      #11 reset_n = 1'b1;
      tick(1);
      chk("idle_ready", cmd_if.cmd_ready, 1);

      // forward 4 steps, period 10
      send(1'b1, 8'd4, 16'd10);
      chk("t1_busy", busy, 1);
      chk("t1_ready", cmd_if.cmd_ready, 0);
      tick(9);
      chk("t1_ab9", {a, b}, 2'b00);
      tick(1);
      chk("t1_ab10", {a, b}, 2'b10);
      chk("t1_pos10", position, 1);
      tick(10);
      chk("t1_ab20", {a, b}, 2'b11);
      tick(10);
      chk("t1_ab30", {a, b}, 2'b01);
      tick(10);
      chk("t1_ab40", {a, b}, 2'b00);
      chk("t1_pos", position, 4);
      chk("t1_done", done, 1);
      chk("t1_busy_end", busy, 0);
      tick(1);
      chk("t1_done_off", done, 0);
      chk("t1_ready_end", cmd_if.cmd_ready, 1);

      // reverse 6 steps, period 3, wraps through 0; a stray request while busy
      send(1'b0, 8'd6, 16'd3);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_dir    = 1'b1;
      cmd_if.cmd_steps  = 8'd0;
      cmd_if.cmd_period = 16'd1;
      chk("t2_ready_busy", cmd_if.cmd_ready, 0);
      for (int i = 0; i < 6; i++) begin
         tick(3);
         if (i == 1) cmd_if.cmd_valid = 1'b0;
         chk($sformatf("t2_ab%0d", i), {a, b}, seq2_ab[i]);
         chk($sformatf("t2_pos%0d", i), position, seq2_pos[i]);
      end
      chk("t2_done", done, 1);
      tick(1);
      chk("t2_ready", cmd_if.cmd_ready, 1);

      // zero steps: immediate done, no motion
      send(1'b1, 8'd0, 16'd7);
      chk("t3_done", done, 1);
      chk("t3_busy", busy, 0);
      tick(1);
      chk("t3_done_off", done, 0);
      chk("t3_ab", {a, b}, 2'b11);
      chk("t3_pos", position, 254);

      // abort while idle is ignored
      abort = 1'b1;
      tick(2);
      chk("idle_abort_ready", cmd_if.cmd_ready, 1);
      chk("idle_abort_done", done, 0);
      chk("idle_abort_ab", {a, b}, 2'b11);
      abort = 1'b0;

      // period 0 acts as 1
      send(1'b1, 8'd3, 16'd0);
      tick(1);
      chk("t4_ab1", {a, b}, 2'b01);
      chk("t4_pos1", position, 255);
      tick(1);
      chk("t4_ab2", {a, b}, 2'b00);
      chk("t4_pos2", position, 0);
      tick(1);
      chk("t4_ab3", {a, b}, 2'b10);
      chk("t4_pos3", position, 1);
      chk("t4_done", done, 1);
      tick(1);

      // abort between edges after 7 transitions
      send(1'b1, 8'd100, 16'd5);
      for (int i = 0; i < 7; i++) begin
         tick(5);
         chk($sformatf("t5_ab%0d", i), {a, b}, seq5_ab[i]);
      end
      chk("t5_pos7", position, 8);
      chk("t5_busy", busy, 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t5_done", done, 1);
      chk("t5_ab_end", {a, b}, 2'b00);
      chk("t5_pos_end", position, 8);
      cmd_if.cmd_dir    = 1'b0;
      cmd_if.cmd_steps  = 8'd1;
      cmd_if.cmd_period = 16'd1;
      cmd_if.cmd_valid  = 1'b1;
      tick(1);
      chk("t5_ready_next", cmd_if.cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
      chk("t5_next_busy", busy, 1);
      tick(1);
      chk("t5_next_ab", {a, b}, 2'b01);
      chk("t5_next_pos", position, 7);
      chk("t5_next_done", done, 1);
      tick(1);

      // abort coinciding with a due edge still emits that transition
      send(1'b1, 8'd100, 16'd4);
      tick(3);
      chk("t6_ab_pre", {a, b}, 2'b01);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t6_ab", {a, b}, 2'b00);
      chk("t6_pos", position, 8);
      chk("t6_done", done, 1);
      tick(1);

      // reset mid-command
      send(1'b0, 8'd50, 16'd2);
      tick(42);
      chk("t7_ab_mid", {a, b}, 2'b01);
      chk("t7_pos_mid", position, 243);
      reset_n = 1'b0;
      #1;
      chk("t7_rst_ab", {a, b}, 0);
      chk("t7_rst_pos", position, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_ready", cmd_if.cmd_ready, 1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk($sformatf("t7_no_done%0d", i), done, 0);
      end
      send(1'b1, 8'd1, 16'd1);
      tick(1);
      chk("t7_fresh_ab", {a, b}, 2'b10);
      chk("t7_fresh_pos", position, 1);
      chk("t7_fresh_done", done, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
